neokeon_pi_shift_unit: RTL and testbench
========================================

// Module: neokeon_pi_shift_unit
// PURPOSE
//  Parametrised, pipelined Noekeon Pi permutation unit: Pi1 (rotate left) or Pi2 (rotate right),
//  selected per transaction, applied to a 4-word state. Word 0 passes unchanged; words 1..3 rotate.
//  Valid/ready handshake on both sides with a 2-entry output buffer, so a stalled round core
//  never drops a state. Sits between Theta and Gamma in the round datapath; also reusable in the
//  decryption path.
// PARAMETERS
//  WORD_W  32  word width in bits; state width = 4*WORD_W
//  ROT1    1   rotation amount for word 1 (taken mod WORD_W)
//  ROT2    5   rotation amount for word 2 (taken mod WORD_W)
//  ROT3    2   rotation amount for word 3 (taken mod WORD_W)
//  TAG_W   4   sideband tag width, carried with each state unchanged
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  in_valid   in   1         input state valid
//  in_ready   out  1         unit accepts input this cycle
//  in_mode    in   1         0 = Pi1 (ROTL), 1 = Pi2 (ROTR); sampled with in_data
//  in_data    in   4*WORD_W  state {a0,a1,a2,a3}; a0 = MSBs
//  in_tag     in   TAG_W     sideband tag
//  out_valid  out  1         output state valid
//  out_ready  in   1         downstream accepts output
//  out_data   out  4*WORD_W  permuted state {a0,a1',a2',a3'}
//  out_tag    out  TAG_W     tag of the state on out_data
//  busy       out  1         any entry held (count != 0)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transfer): count=0; out_valid=0; out_data=0; out_tag=0;
//    busy=0; in_ready=0 while rst high, 1 from the first cycle after release. Held entries discarded.
//  - Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
//  - Permutation is computed combinationally on the input side and the result is registered; the
//    buffer holds permuted states only. Latency 1 cycle: state accepted at edge N is on out_data
//    after edge N when the buffer was empty.
//  - Pi1: a1'=ROTL(a1,ROT1), a2'=ROTL(a2,ROT2), a3'=ROTL(a3,ROT3). Pi2: same amounts, ROTR.
//    a0'=a0. Rotation amount 0 (or a multiple of WORD_W) = identity.
//  - Buffer: 2 entries, FIFO order, count 0..2. in_ready = (count != 2) & !rst. No combinational
//    path from out_ready to in_ready.
//  - Entry mode: out_valid = (count != 0); out_data/out_tag = head entry.
//  - Push only (count 0->1, 1->2); pop only (2->1, 1->0); push+pop at count 1: count stays 1 and
//    the new state becomes head on the next cycle; push+pop at count 2 is impossible (in_ready=0).
//  - While out_valid & !out_ready, out_data and out_tag are held bit-stable.
//  - in_mode, in_data, in_tag ignored when no input transfer takes place.
// STRUCTURE
//  - Shared package neokeon_pkg: localparams MODE_PI1=1'b0, MODE_PI2=1'b1; NK_WORD_W=32;
//    NK_PI_ROT1=1, NK_PI_ROT2=5, NK_PI_ROT3=2.
//  - Sub-module neokeon_rot_word (params WORD_W, AMT; inputs word, dir; output rotated word),
//    instantiated 3x; purely combinational.
//  - Top: mode mux inside rot_word, 2-entry register buffer (head/tail storage + count).
// TESTING
//  1 Pi2 single: rst pulse; in {32'h0,32'h1,32'h1,32'h1}, mode=1, out_ready=1 ->
//    after 1 cycle out {0000_0000,8000_0000,0800_0000,4000_0000}, out_valid for exactly 1 cycle.
//  2 Pi1 single: same input, mode=0 -> out {0000_0000,0000_0002,0000_0020,0000_0004};
//    Pi1 result fed back with mode=1 -> original state (inverse check).
//  3 Backpressure: out_ready=0, push tags 1,2 -> in_ready=0 after second push; third state held
//    upstream; release out_ready -> tags 1,2,3 in order, out_data stable while stalled.
//  4 Streaming: in_valid=1, out_ready=1 for 16 cycles, alternating modes, random data -> 16 outputs
//    in order, one per cycle, each matching reference model; count never exceeds 1.
//  5 Async reset mid-operation: 2 entries held, assert rst between edges -> out_valid=0,
//    busy=0 immediately; after release no stale entry emerges.
//  6 Parameter sweep: WORD_W=16, ROT2=16 (identity) and ROT1=17 (=1) -> matches model.

Source files
------------

// File: rtl/neokeon_pkg.sv
// Shared constants and types for the Noekeon round datapath blocks.
package neokeon_pkg;

  localparam logic MODE_PI1 = 1'b0;  // rotate left
  localparam logic MODE_PI2 = 1'b1;  // rotate right

  localparam int NK_WORD_W  = 32;
  localparam int NK_PI_ROT1 = 1;
  localparam int NK_PI_ROT2 = 5;
  localparam int NK_PI_ROT3 = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_level_e;

endpackage : neokeon_pkg

// File: rtl/neokeon_rot_word.sv
// Combinational fixed-amount word rotator; direction chosen per transaction.
module neokeon_rot_word
  import neokeon_pkg::*;
#(
  parameter int WORD_W = NK_WORD_W,
  parameter int AMT    = 0
) (
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_dir,
  output logic [WORD_W-1:0] o_word
);

  localparam int SH = AMT % WORD_W;

  logic [2*WORD_W-1:0] w_dbl;
  logic [2*WORD_W-1:0] w_rotl_full;
  logic [2*WORD_W-1:0] w_rotr_full;

  // Rotating a doubled word avoids the shift-by-WORD_W corner when SH is 0.
  assign w_dbl       = {i_word, i_word};
  assign w_rotl_full = w_dbl << SH;
  assign w_rotr_full = w_dbl >> SH;

  assign o_word = (i_dir == MODE_PI2) ? w_rotr_full[WORD_W-1:0]
                                      : w_rotl_full[2*WORD_W-1:WORD_W];

endmodule : neokeon_rot_word

// File: rtl/neokeon_pi_shift_unit.sv
// Noekeon Pi1/Pi2 permutation with a registered 2-entry output buffer (valid/ready both sides).
module neokeon_pi_shift_unit
  import neokeon_pkg::*;
#(
  parameter int WORD_W = NK_WORD_W,
  parameter int ROT1   = NK_PI_ROT1,
  parameter int ROT2   = NK_PI_ROT2,
  parameter int ROT3   = NK_PI_ROT3,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [4*WORD_W-1:0] in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*WORD_W-1:0] out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  localparam int STATE_W = 4 * WORD_W;

  logic [WORD_W-1:0]  w_a0, w_a1, w_a2, w_a3;
  logic [WORD_W-1:0]  w_r1, w_r2, w_r3;
  logic [STATE_W-1:0] w_perm;

  assign {w_a0, w_a1, w_a2, w_a3} = in_data;

  neokeon_rot_word #(.WORD_W(WORD_W), .AMT(ROT1)) u_rot1 (
    .i_word (w_a1),
    .i_dir  (in_mode),
    .o_word (w_r1)
  );

  neokeon_rot_word #(.WORD_W(WORD_W), .AMT(ROT2)) u_rot2 (
    .i_word (w_a2),
    .i_dir  (in_mode),
    .o_word (w_r2)
  );

  neokeon_rot_word #(.WORD_W(WORD_W), .AMT(ROT3)) u_rot3 (
    .i_word (w_a3),
    .i_dir  (in_mode),
    .o_word (w_r3)
  );

  assign w_perm = {w_a0, w_r1, w_r2, w_r3};

  buf_level_e         r_count;
  logic [STATE_W-1:0] r_head_data, r_tail_data;
  logic [TAG_W-1:0]   r_head_tag, r_tail_tag;

  logic       w_push, w_pop;
  logic       w_in_ready;
  logic       w_load_head, w_load_tail, w_head_from_tail;
  buf_level_e w_count_nxt;

  // in_ready depends only on registered count and reset, never on out_ready.
  assign w_in_ready = (r_count != BUF_FULL) & ~rst;
  assign w_push     = in_valid & w_in_ready;
  assign w_pop      = (r_count != BUF_EMPTY) & out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_count_nxt      = r_count;
    w_load_head      = 1'b0;
    w_load_tail      = 1'b0;
    w_head_from_tail = 1'b0;
    case (r_count)
      BUF_EMPTY: begin
        if (w_push) begin
          w_load_head = 1'b1;
          w_count_nxt = BUF_ONE;
        end
      end
      BUF_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_load_tail = 1'b1;
            w_count_nxt = BUF_FULL;
          end
          2'b01:   w_count_nxt = BUF_EMPTY;
          2'b11:   w_load_head = 1'b1;
          default: w_count_nxt = BUF_ONE;
        endcase
      end
      BUF_FULL: begin
        if (w_pop) begin
          w_head_from_tail = 1'b1;
          w_count_nxt      = BUF_ONE;
        end
      end
      default: w_count_nxt = BUF_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer storage is reset too, because out_data/out_tag must read
      // zero after reset; this is a deliberate choice for a two-entry buffer.
      r_count     <= BUF_EMPTY;
      r_head_data <= '0;
      r_head_tag  <= '0;
      r_tail_data <= '0;
      r_tail_tag  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_load_head) begin
        r_head_data <= w_perm;
        r_head_tag  <= in_tag;
      end else if (w_head_from_tail) begin
        r_head_data <= r_tail_data;
        r_head_tag  <= r_tail_tag;
      end
      if (w_load_tail) begin
        r_tail_data <= w_perm;
        r_tail_tag  <= in_tag;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_count != BUF_EMPTY);
  assign out_data  = r_head_data;
  assign out_tag   = r_head_tag;
  assign busy      = (r_count != BUF_EMPTY);

endmodule : neokeon_pi_shift_unit

// File: tb/tb_neokeon_pi_shift_unit.sv
// Self-checking bench for neokeon_pi_shift_unit: directed scenarios plus randomized streams vs a bit-level model.
module tb_neokeon_pi_shift_unit;
  import neokeon_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
  logic         busy;

  // Second instance for the narrow-word / wrapped-rotation sweep.
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic        s_in_mode = 1'b0;
  logic [63:0] s_in_data = '0;
  logic [3:0]  s_in_tag = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [63:0] s_out_data;
  logic [3:0]  s_out_tag;
  logic        s_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neokeon_pi_shift_unit u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  neokeon_pi_shift_unit #(
    .WORD_W (16),
    .ROT1   (17),
    .ROT2   (16),
    .ROT3   (2),
    .TAG_W  (4)
  ) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_mode   (s_in_mode),
    .in_data   (s_in_data),
    .in_tag    (s_in_tag),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_tag   (s_out_tag),
    .busy      (s_busy)
  );

  // Bit-level reference: word k sits at bits [(3-k)*w +: w]; bit i moves to (i +/- s) mod w.
  function automatic logic [127:0] pi_model(input logic [127:0] st, input logic mode,
                                             input int w, input int r1, input int r2, input int r3);
    logic [127:0] res;
    int amt [4];
    int s;
    int d;
    amt[0] = 0; amt[1] = r1; amt[2] = r2; amt[3] = r3;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      s = amt[k] % w;
      for (int i = 0; i < w; i++) begin
        d = (mode == MODE_PI2) ? ((i - s + w) % w) : ((i + s) % w);
        res[(3-k)*w + d] = st[(3-k)*w + i];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] model32(input logic [127:0] st, input logic mode);
    return pi_model(st, mode, 32, NK_PI_ROT1, NK_PI_ROT2, NK_PI_ROT3);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: out_valid=%b busy=%b in_ready=%b, required 0 0 0",
               out_valid, busy, in_ready);
    end
    checks++;
    if (out_data !== 128'h0 || out_tag !== 4'h0) begin
      failures++;
      $display("FAIL reset_data: out_data=%h out_tag=%h, required 0 0", out_data, out_tag);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_pi2_single();
    logic [127:0] exp_const;
    exp_const = {32'h0000_0000, 32'h8000_0000, 32'h0800_0000, 32'h4000_0000};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = MODE_PI2;
    in_data   = {32'h0, 32'h1, 32'h1, 32'h1};
    in_tag    = 4'h9;
    step();
    in_valid = 1'b0;
    in_data  = rand128();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_const || out_tag !== 4'h9) begin
      failures++;
      $display("FAIL pi2_single: valid=%b data=%h tag=%h, required 1 %h 9",
               out_valid, out_data, out_tag, exp_const);
    end
    checks++;
    if (out_data !== model32({32'h0, 32'h1, 32'h1, 32'h1}, MODE_PI2)) begin
      failures++;
      $display("FAIL pi2_model: data=%h, required %h", out_data,
               model32({32'h0, 32'h1, 32'h1, 32'h1}, MODE_PI2));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pi2_one_cycle: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_pi1_inverse();
    logic [127:0] orig;
    logic [127:0] exp_const;
    logic [127:0] fwd;
    orig      = {32'h0, 32'h1, 32'h1, 32'h1};
    exp_const = {32'h0000_0000, 32'h0000_0002, 32'h0000_0020, 32'h0000_0004};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = MODE_PI1;
    in_data   = orig;
    in_tag    = 4'h3;
    step();
    in_valid = 1'b0;
    fwd      = out_data;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_const) begin
      failures++;
      $display("FAIL pi1_single: valid=%b data=%h, required 1 %h", out_valid, out_data, exp_const);
    end
    step();
    in_valid = 1'b1;
    in_mode  = MODE_PI2;
    in_data  = fwd;
    in_tag   = 4'h4;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== orig || out_tag !== 4'h4) begin
      failures++;
      $display("FAIL pi1_inverse: valid=%b data=%h tag=%h, required 1 %h 4",
               out_valid, out_data, out_tag, orig);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [127:0] d [3];
    logic [127:0] e [3];
    logic         m [3];
    int           bad_stable;
    for (int i = 0; i < 3; i++) begin
      d[i] = rand128();
      m[i] = 1'($urandom_range(0, 1));
      e[i] = model32(d[i], m[i]);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_mode  = m[i];
      in_data  = d[i];
      in_tag   = 4'(i + 1);
      step();
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b busy=%b out_valid=%b, required 0 1 1",
               in_ready, busy, out_valid);
    end
    in_mode = m[2];
    in_data = d[2];
    in_tag  = 4'd3;
    bad_stable = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_data !== e[0] || out_tag !== 4'd1 || in_ready !== 1'b0) bad_stable++;
    end
    checks++;
    if (bad_stable != 0) begin
      failures++;
      $display("FAIL bp_stall_stable: %0d unstable cycles, required 0 (head %h tag 1)",
               bad_stable, e[0]);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_data !== e[1]) begin
      failures++;
      $display("FAIL bp_second: valid=%b tag=%h data=%h, required 1 2 %h",
               out_valid, out_tag, out_data, e[1]);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_data !== e[2]) begin
      failures++;
      $display("FAIL bp_third: valid=%b tag=%h data=%h, required 1 3 %h",
               out_valid, out_tag, out_data, e[2]);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_streaming();
    logic [127:0] exp_q [$];
    logic [3:0]   tag_q [$];
    logic [127:0] exp_d;
    logic [3:0]   exp_t;
    logic [127:0] d;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d        = rand128();
      in_valid = 1'b1;
      in_mode  = 1'(i % 2);
      in_data  = d;
      in_tag   = 4'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d]: in_ready=%b, required 1", i, in_ready);
      end
      exp_q.push_back(model32(d, 1'(i % 2)));
      tag_q.push_back(4'(i));
      step();
      exp_d = exp_q.pop_front();
      exp_t = tag_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_tag !== exp_t) begin
        failures++;
        $display("FAIL stream_out[%0d]: valid=%b data=%h tag=%h, required 1 %h %h",
                 i, out_valid, out_data, out_tag, exp_d, exp_t);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_async_reset();
    int stale;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_mode  = 1'($urandom_range(0, 1));
      in_data  = rand128();
      in_tag   = 4'(10 + i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL areset_pre: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 128'h0) begin
      failures++;
      $display("FAIL areset_now: out_valid=%b busy=%b in_ready=%b data=%h, required 0 0 0 0",
               out_valid, busy, in_ready, out_data);
    end
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_stale: stale_cycles=%0d in_ready=%b, required 0 1", stale, in_ready);
    end
  endtask

  task automatic test_param_sweep();
    logic [127:0] d;
    logic [127:0] e;
    logic         m;
    s_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d          = {64'h0, $urandom, $urandom};
      m          = 1'(i % 2);
      e          = pi_model(d, m, 16, 17, 16, 2);
      s_in_valid = 1'b1;
      s_in_mode  = m;
      s_in_data  = d[63:0];
      s_in_tag   = 4'(i);
      step();
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== e[63:0] || s_out_tag !== 4'(i)) begin
        failures++;
        $display("FAIL sweep16[%0d]: valid=%b data=%h tag=%h, required 1 %h %h",
                 i, s_out_valid, s_out_data, s_out_tag, e[63:0], 4'(i));
      end
      checks++;
      if (s_out_data[31:16] !== d[31:16]) begin
        failures++;
        $display("FAIL sweep16_identity[%0d]: word2=%h, required %h", i, s_out_data[31:16], d[31:16]);
      end
    end
    s_in_valid = 1'b0;
    step();
    checks++;
    if (s_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep16_end: out_valid=%b, required 0", s_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pi2_single();
    test_pi1_inverse();
    test_backpressure();
    test_streaming();
    test_async_reset();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_neokeon_pi_shift_unit
